// File: rtl/instr_encoder.sv
// Instruction encoder/loader: packs decoded fields into 16-bit words, buffers them and writes them into instruction memory.
// Optional illegal-opcode filtering is enabled with `define ENC_ILLEGAL_EN.
module instr_encoder #(
  parameter int          AW      = 8,
  parameter int          DEPTH   = 4,
  parameter logic [3:0]  HALT_OP = 4'hF,
  parameter logic [3:0]  MAX_OP  = 4'hB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    opcode,
  input  logic [3:0]    rd,
  input  logic [3:0]    rs,
  input  logic [3:0]    rt,
  input  logic          imm_sel,
  input  logic [7:0]    imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_ready,
  output logic          done,
  output logic          err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

  generate
    if (MAX_OP >= HALT_OP || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("instr_encoder: invalid parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  logic [15:0]   r_fifo [DEPTH];
  logic [PW:0]   r_wr_ptr;
  logic [PW:0]   r_rd_ptr;
  logic [AW-1:0] r_addr;

  logic          w_restart;
  logic [PW:0]   w_count;
  logic          w_empty;
  logic          w_full;
  logic [15:0]   w_word;
  logic          w_accept;
  logic          w_illegal;
  logic          w_push;
  logic          w_pop;

  assign w_restart = !rst || clear;
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == CNT_FULL);
  assign w_word    = imm_sel ? {opcode, rd, imm} : {opcode, rd, rs, rt};

  assign in_ready  = !w_full && (r_state == S_LOAD);
  assign w_accept  = in_valid && in_ready;

`ifdef ENC_ILLEGAL_EN
  logic r_err;
  assign w_illegal = (opcode > MAX_OP) && (opcode < HALT_OP);
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_illegal = 1'b0;
  assign err       = 1'b0;
`endif

  assign w_push = w_accept && !w_illegal;

  // The write strobe is masked during restart so a dropped head is never committed.
  assign mem_we    = !w_empty && (r_state != S_DONE) && !w_restart;
  assign w_pop     = mem_we && mem_ready;
  assign mem_addr  = r_addr;
  assign mem_wdata = w_empty ? 16'h0000 : r_fifo[r_rd_ptr[PW-1:0]];
  assign done      = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[PW-1:0]] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_state  <= S_LOAD;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_addr   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + CNT_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + CNT_ONE;
        r_addr   <= r_addr + AW'(1);
      end
      case (r_state)
        S_LOAD: begin
          if (w_accept && opcode == HALT_OP) begin
            r_state <= S_DRAIN;
          end
        end
        // HALT is the last word pushed, so popping the final entry commits it.
        S_DRAIN: begin
          if (w_pop && w_count == CNT_ONE) begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
